mem_req_queue: RTL

Request front-end that sits directly upstream of the byte-wide memory wrapper. It accepts read/write requests on a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It issues at most one request per cycle onto the wrapper's single shared-address port and returns read data, tagged with its address, as a response pulse after a fixed latency.

---
 rtl/mem_req_queue_if.sv | 40 ++++
 rtl/mem_req_queue.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mem_req_queue_if.sv
// Bundle of request, memory-port and response signals for mem_req_queue.
// The queue takes the slave view; the requester/memory side takes the master view.
interface mem_req_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) ();
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_data_out;

  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;

  logic [LVL_W-1:0]  level;
  logic              busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data_out,
    output req_ready, mem_address, mem_data_in, mem_read_en, mem_write_en,
    output rsp_valid, rsp_addr, rsp_data, level, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data_out,
    input  req_ready, mem_address, mem_data_in, mem_read_en, mem_write_en,
    input  rsp_valid, rsp_addr, rsp_data, level, busy
  );
endinterface

// File: rtl/mem_req_queue.sv
// Request FIFO in front of the byte-wide memory wrapper: issues one request per
// cycle on the shared address port and returns tagged read data after RD_LAT.
module mem_req_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input logic            clk,
  input logic            rst_n,
  mem_req_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  // Issue-stall hook; tied off, kept as a named net so a stall source can be added later.
  logic issue_hold;
  assign issue_hold = 1'b0;

  logic              fifo_we_q    [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [DEPTH];
  logic [DATA_W-1:0] fifo_wdata_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push, pop;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;

  logic [RD_LAT:0]   pipe_v_q, pipe_v_d;
  logic [ADDR_W-1:0] pipe_a_q [RD_LAT+1];
  logic [ADDR_W-1:0] pipe_a_d [RD_LAT+1];

  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  // Ready looks only at the registered level: no same-cycle bypass when full.
  assign bus.req_ready = (level_q < LVL_FULL);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (level_q != '0) && !issue_hold;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]    <= bus.req_we;
      fifo_addr_q[wr_ptr_q]  <= bus.req_addr;
      fifo_wdata_q[wr_ptr_q] <= bus.req_wdata;
    end
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    if (pop) begin
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_wdata_d = fifo_wdata_q[rd_ptr_q];
      mem_rd_d    = !fifo_we_q[rd_ptr_q];
      mem_wr_d    = fifo_we_q[rd_ptr_q];
    end
  end

  // Stage 0 loads with the strobe itself, so the tail lines up with data_out.
  always_comb begin
    pipe_v_d    = pipe_v_q;
    pipe_a_d    = pipe_a_q;
    pipe_v_d[0] = mem_rd_d;
    pipe_a_d[0] = mem_addr_d;
    for (int i = 1; i <= RD_LAT; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_a_d[i] = pipe_a_q[i-1];
    end
  end

  always_comb begin
    rsp_valid_d = pipe_v_q[RD_LAT];
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    if (pipe_v_q[RD_LAT]) begin
      rsp_addr_d = pipe_a_q[RD_LAT];
      rsp_data_d = bus.mem_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      pipe_v_q    <= '0;
      for (int i = 0; i <= RD_LAT; i++) pipe_a_q[i] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      pipe_v_q    <= pipe_v_d;
      pipe_a_q    <= pipe_a_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.mem_address  = mem_addr_q;
  assign bus.mem_data_in  = mem_wdata_q;
  assign bus.mem_read_en  = mem_rd_q;
  assign bus.mem_write_en = mem_wr_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_addr     = rsp_addr_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.level        = level_q;
  assign bus.busy         = (level_q != '0) | (|pipe_v_q) | mem_rd_q;

endmodule
